scope_capture: RTL and testbench

Parametrised multi-channel trigger/capture engine for the oscilloscope datapath. Accepts strobed ADC samples for N_CH channels, keeps a circular sample buffer, detects a hysteretic level trigger on a selectable channel (auto / normal / single modes), and holds a pre/post-trigger frame for the VGA path to read by column index. Successor to the single-channel FIFO capture: adds channel count, programmable pre-trigger depth, hysteresis, auto timeout and a frame-release handshake.

---
 rtl/scope_pkg.sv | 18 +
 rtl/scope_capture_trig_detect.sv | 66 ++++++
 rtl/scope_capture.sv | 171 +++++++++++++++++
 tb/tb_scope_capture.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared types and constants for the oscilloscope capture engine.
package scope_pkg;

  // Capture sequencer states; encodings are visible on the state port.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    HOLD  = 3'd4
  } capture_state_t;

  // Trigger mode selector values; 2'b11 behaves as normal.
  localparam logic [1:0] TM_AUTO   = 2'b00;
  localparam logic [1:0] TM_NORMAL = 2'b01;
  localparam logic [1:0] TM_SINGLE = 2'b10;

endpackage : scope_pkg

// File: rtl/scope_capture_trig_detect.sv
// Hysteretic level-trigger detector: selects one channel from the packed
// sample word, derives saturating arm thresholds around the level and
// fires on the first qualifying sample once armed.
module trig_detect #(
  parameter int N_CH = 2,
  parameter int DW   = 12,
  parameter int HYST = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_valid,
  input  logic [N_CH*DW-1:0] i_data,
  input  logic [3:0]         i_ch,
  input  logic [DW-1:0]      i_level,
  input  logic               i_edge,
  output logic               o_fire
);

  localparam logic [DW:0] HYST_X = (DW+1)'(HYST);

  logic [DW-1:0] w_sample;
  logic [DW:0]   w_lvl_x;
  logic [DW:0]   w_lo_x;
  logic [DW:0]   w_hi_x;
  logic [DW-1:0] w_lo;
  logic [DW-1:0] w_hi;
  logic          w_arm_hit;
  logic          w_fire_hit;
  logic          r_armed;

  // Channel select; out-of-range channel numbers fall back to ch0.
  always_comb begin
    w_sample = i_data[DW-1:0];
    for (int unsigned c = 1; c < N_CH; c++) begin
      if (i_ch == 4'(c)) begin
        w_sample = i_data[c*DW +: DW];
      end
    end
  end

  // Arm thresholds level-HYST / level+HYST, saturated to the sample range.
  always_comb begin
    w_lvl_x    = {1'b0, i_level};
    w_lo_x     = w_lvl_x - HYST_X;
    w_hi_x     = w_lvl_x + HYST_X;
    w_lo       = (w_lvl_x >= HYST_X) ? w_lo_x[DW-1:0] : '0;
    w_hi       = w_hi_x[DW] ? '1 : w_hi_x[DW-1:0];
    w_arm_hit  = i_edge ? (w_sample > w_hi) : (w_sample < w_lo);
    w_fire_hit = i_edge ? (w_sample <= i_level) : (w_sample >= i_level);
    o_fire     = i_valid && r_armed && w_fire_hit;
  end

  // Armed flag: held clear outside the armed window, set by a sample
  // beyond the hysteresis threshold on the far side of the level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_armed <= 1'b0;
    end else if (i_clear) begin
      r_armed <= 1'b0;
    end else if (i_valid && w_arm_hit) begin
      r_armed <= 1'b1;
    end
  end

endmodule : trig_detect

// File: rtl/scope_capture.sv
// Multi-channel trigger/capture engine: circular sample buffer, hysteretic
// level trigger with auto/normal/single modes, and a held pre/post-trigger
// frame read back by frame-relative column index.
module scope_capture
  import scope_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int DW      = 12,
  parameter int AW      = 10,
  parameter int HYST    = 8,
  parameter int AUTO_TO = 1048576
) (
  input  logic               CLK,
  input  logic               RSTB,
  input  logic               smp_valid,
  input  logic [N_CH*DW-1:0] smp_data,
  input  logic [3:0]         trig_ch,
  input  logic [DW-1:0]      trig_level,
  input  logic               trig_edge,
  input  logic [1:0]         trig_mode,
  input  logic               arm,
  input  logic [AW-1:0]      pre_cnt,
  input  logic [AW-1:0]      post_cnt,
  input  logic [AW-1:0]      rd_addr,
  input  logic               rd_done,
  output logic [N_CH*DW-1:0] rd_data,
  output logic               frame_valid,
  output logic               triggered,
  output logic               forced,
  output logic [2:0]         state
);

  localparam int DEPTH = 2**AW;
  localparam int TW    = $clog2(AUTO_TO + 1);
  localparam logic [TW-1:0] AUTO_LAST = TW'(AUTO_TO - 1);

  capture_state_t r_state;
  capture_state_t w_next;

  logic [N_CH*DW-1:0] r_mem [DEPTH];
  logic [N_CH*DW-1:0] r_rd_data;
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_fill;
  logic [AW-1:0]      r_post;
  logic [TW-1:0]      r_auto;
  logic [AW-1:0]      r_start;
  logic               r_trig;
  logic               r_forced;

  logic               w_single;
  logic               w_auto;
  logic [AW-1:0]      w_limit;
  logic               w_post_full;
  logic               w_post_last;
  logic               w_wr;
  logic               w_det_valid;
  logic               w_fire;
  logic               w_timeout;
  logic               w_take;
  logic [AW-1:0]      w_rd_addr;

  // Mode decode, post-length clamp and write/trigger qualifiers.
  // ~pre_cnt equals DEPTH-1-pre_cnt, the room left after the pre samples
  // and the trigger sample, so the frame never overlaps itself.
  always_comb begin
    w_single    = (trig_mode == TM_SINGLE);
    w_auto      = (trig_mode == TM_AUTO);
    w_limit     = (post_cnt < ~pre_cnt) ? post_cnt : ~pre_cnt;
    w_post_full = (r_post == w_limit);
    w_wr        = smp_valid &&
                  ((r_state == PRE) || (r_state == ARMED) ||
                   ((r_state == POST) && !w_post_full));
    w_post_last = w_post_full ||
                  (w_wr && (({1'b0, r_post} + (AW+1)'(1)) == {1'b0, w_limit}));
    w_det_valid = smp_valid && (r_state == ARMED);
    w_timeout   = w_auto && w_det_valid && !w_fire && (r_auto == AUTO_LAST);
    w_take      = w_fire || w_timeout;
    w_rd_addr   = r_start + rd_addr;
  end

  trig_detect #(
    .N_CH (N_CH),
    .DW   (DW),
    .HYST (HYST)
  ) u_trig_detect (
    .i_clk   (CLK),
    .i_rst_n (RSTB),
    .i_clear (r_state != ARMED),
    .i_valid (w_det_valid),
    .i_data  (smp_data),
    .i_ch    (trig_ch),
    .i_level (trig_level),
    .i_edge  (trig_edge),
    .o_fire  (w_fire)
  );

  // Next-state logic for the capture sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!w_single || arm) w_next = PRE;
      PRE:     if (r_fill == pre_cnt) w_next = ARMED;
      ARMED:   if (w_take) w_next = POST;
      POST:    if (w_post_last) w_next = HOLD;
      HOLD:    if (rd_done) w_next = w_single ? IDLE : PRE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Write pointer, per-phase counters, frame start and trigger pulses.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
      r_post   <= '0;
      r_auto   <= '0;
      r_start  <= '0;
      r_trig   <= 1'b0;
      r_forced <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);

      if (r_state != PRE) r_fill <= '0;
      else if (w_wr)      r_fill <= r_fill + AW'(1);

      if (r_state != POST) r_post <= '0;
      else if (w_wr)       r_post <= r_post + AW'(1);

      if (r_state != ARMED)  r_auto <= '0;
      else if (w_det_valid)  r_auto <= r_auto + TW'(1);

      if (w_take) r_start <= r_wr_ptr - pre_cnt;

      r_trig   <= w_take;
      r_forced <= w_timeout;
    end
  end

  // Sample buffer write port; contents survive reset.
  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wr_ptr] <= smp_data;
  end

  // Registered frame-relative read port, active in every state.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[w_rd_addr];
    end
  end

  // Output mapping.
  always_comb begin
    rd_data     = r_rd_data;
    frame_valid = (r_state == HOLD);
    triggered   = r_trig;
    forced      = r_forced;
    state       = r_state;
  end

endmodule : scope_capture

// File: tb/tb_scope_capture.sv
// Directed self-checking bench for scope_capture with a scoreboard queue.
module tb_scope_capture;

  logic        CLK = 1'b0;
  logic        RSTB = 1'b1;
  logic        smp_valid = 1'b0;
  logic [23:0] smp_data = '0;
  logic [3:0]  trig_ch = '0;
  logic [11:0] trig_level = '0;
  logic        trig_edge = 1'b0;
  logic [1:0]  trig_mode = 2'b01;
  logic        arm = 1'b0;
  logic [9:0]  pre_cnt = '0;
  logic [9:0]  post_cnt = '0;
  logic [9:0]  rd_addr = '0;
  logic        rd_done = 1'b0;
  logic [23:0] rd_data;
  logic        frame_valid;
  logic        triggered;
  logic        forced;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  scope_capture #(
    .N_CH    (2),
    .DW      (12),
    .AW      (10),
    .HYST    (8),
    .AUTO_TO (64)
  ) dut (
    .CLK         (CLK),
    .RSTB        (RSTB),
    .smp_valid   (smp_valid),
    .smp_data    (smp_data),
    .trig_ch     (trig_ch),
    .trig_level  (trig_level),
    .trig_edge   (trig_edge),
    .trig_mode   (trig_mode),
    .arm         (arm),
    .pre_cnt     (pre_cnt),
    .post_cnt    (post_cnt),
    .rd_addr     (rd_addr),
    .rd_done     (rd_done),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .triggered   (triggered),
    .forced      (forced),
    .state       (state)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1ms;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] rampw(input int k);
    return {12'(4095 - k), 12'(k)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%0d expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
      end
    end
  endtask

  // Drive one cycle of stimulus and settle just after the active edge.
  task automatic step(input logic v, input logic [23:0] d);
    smp_valid = v;
    smp_data  = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [9:0] a, output logic [23:0] d);
    rd_addr = a;
    step(1'b1, 24'hABCABC);
    d = rd_data;
  endtask

  initial begin
    int trig_k, fv_k, n_trig, n_bad, n_armed, n_at;
    logic [2:0] st, trig_st;
    logic trig_f;
    logic [23:0] d;

    // ---- reset state ----
    #1 RSTB = 1'b0;
    #10;
    exp_q.push_back(0); chk("rst0_state", 32'(state));
    exp_q.push_back(0); chk("rst0_fv", 32'(frame_valid));
    exp_q.push_back(0); chk("rst0_trig", 32'(triggered));
    exp_q.push_back(0); chk("rst0_forced", 32'(forced));
    exp_q.push_back(0); chk("rst0_rd_data", 32'(rd_data));
    trig_level = 12'd100; pre_cnt = 10'd4; post_cnt = 10'd200;
    @(negedge CLK) RSTB = 1'b1;
    @(posedge CLK); #1;
    exp_q.push_back(1); chk("rel0_pre", 32'(state));

    // ---- reset in the middle of POST ----
    trig_k = -1;
    for (int k = 0; k < 400; k++) begin
      step(1'b1, rampw(k));
      if (triggered) begin trig_k = k; break; end
    end
    exp_q.push_back(100); chk("mid_trig_sample", 32'(trig_k));
    for (int k = 101; k < 106; k++) step(1'b1, rampw(k));
    exp_q.push_back(3); chk("mid_state_post", 32'(state));
    smp_valid = 1'b0;
    #2 RSTB = 1'b0;
    #1;
    exp_q.push_back(0); chk("midrst_state", 32'(state));
    exp_q.push_back(0); chk("midrst_fv", 32'(frame_valid));
    trig_level = 12'd2048; pre_cnt = 10'd100; post_cnt = 10'd539;
    @(negedge CLK) RSTB = 1'b1;
    @(posedge CLK); #1;
    exp_q.push_back(1); chk("midrst_rel_pre", 32'(state));

    // ---- normal rising capture on a ch0 ramp ----
    trig_k = -1; fv_k = -1; trig_st = '0; trig_f = 1'b1;
    exp_q.push_back(2048);
    exp_q.push_back(3);
    exp_q.push_back(0);
    exp_q.push_back(2587);
    for (int k = 0; k < 3000; k++) begin
      step(1'b1, rampw(k));
      if (triggered && trig_k < 0) begin
        trig_k = k; trig_st = state; trig_f = forced;
      end
      if (frame_valid) begin fv_k = k; break; end
    end
    chk("norm_trig_sample", 32'(trig_k));
    chk("norm_trig_state", 32'(trig_st));
    chk("norm_trig_forced", 32'(trig_f));
    chk("norm_fv_after_last", 32'(fv_k));
    rd(10'd0, d);   exp_q.push_back(32'(rampw(1948))); chk("norm_rd0", 32'(d));
    rd(10'd100, d); exp_q.push_back(32'(rampw(2048))); chk("norm_rd100", 32'(d));
    rd(10'd639, d); exp_q.push_back(32'(rampw(2587))); chk("norm_rd639", 32'(d));
    exp_q.push_back(4); chk("norm_hold_state", 32'(state));
    // next capture: falling edge on ch1, no pre samples
    trig_ch = 4'd1; trig_edge = 1'b1; trig_level = 12'd1000;
    pre_cnt = 10'd0; post_cnt = 10'd3;
    rd_done = 1'b1;
    step(1'b1, {12'd1000, 12'd0});
    rd_done = 1'b0;
    exp_q.push_back(0); chk("norm_done_fv", 32'(frame_valid));
    exp_q.push_back(1); chk("norm_done_pre", 32'(state));

    // ---- falling with hysteresis on ch1 ----
    n_trig = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b1, {12'(995 + (i % 11)), 12'd0});
      if (triggered) n_trig++;
    end
    exp_q.push_back(0); chk("fall_osc_no_trig", 32'(n_trig));
    exp_q.push_back(2); chk("fall_osc_armed", 32'(state));
    step(1'b1, {12'd1010, 12'd0});
    exp_q.push_back(0); chk("fall_1010_no_trig", 32'(triggered));
    step(1'b1, {12'd999, 12'd0});
    exp_q.push_back(1); chk("fall_999_trig", 32'(triggered));
    step(1'b1, {12'd1003, 12'd0});
    step(1'b1, {12'd1004, 12'd0});
    step(1'b1, {12'd1005, 12'd0});
    exp_q.push_back(1); chk("fall_fv", 32'(frame_valid));
    rd(10'd0, d); exp_q.push_back(32'({12'd999, 12'd0}));  chk("fall_rd0", 32'(d));
    rd(10'd3, d); exp_q.push_back(32'({12'd1005, 12'd0})); chk("fall_rd3", 32'(d));
    // next capture: auto mode with constant input that never fires
    trig_mode = 2'b00; trig_ch = 4'd0; trig_edge = 1'b0; trig_level = 12'd2048;
    rd_done = 1'b1;
    step(1'b1, 24'd0);
    rd_done = 1'b0;

    // ---- auto timeout ----
    n_armed = 0; n_at = -1; trig_f = 1'b0;
    for (int i = 0; i < 300; i++) begin
      st = state;
      step(1'b1, 24'd0);
      if (st == 3'd2) n_armed++;
      if (triggered) begin n_at = n_armed; trig_f = forced; break; end
    end
    exp_q.push_back(64); chk("auto_armed_samples", 32'(n_at));
    exp_q.push_back(1);  chk("auto_forced", 32'(trig_f));
    for (int i = 0; i < 3; i++) step(1'b1, 24'd0);
    exp_q.push_back(1); chk("auto_fv", 32'(frame_valid));
    // next: single mode, reader release returns to IDLE
    trig_mode = 2'b10; trig_level = 12'd500; pre_cnt = 10'd2; post_cnt = 10'd2;
    rd_done = 1'b1;
    step(1'b1, 24'd0);
    rd_done = 1'b0;
    exp_q.push_back(0); chk("single_done_idle", 32'(state));

    // ---- single mode ----
    n_bad = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, rampw(k));
      if (state != 3'd0) n_bad++;
    end
    exp_q.push_back(0); chk("single_noarm_idle", 32'(n_bad));
    arm = 1'b1;
    step(1'b0, 24'd0);
    arm = 1'b0;
    exp_q.push_back(1); chk("single_arm_pre", 32'(state));
    trig_k = -1; fv_k = -1; n_trig = 0;
    for (int k = 0; k < 2000; k++) begin
      step(1'b1, rampw(k));
      if (triggered) begin n_trig++; if (trig_k < 0) trig_k = k; end
      if (frame_valid) begin fv_k = k; break; end
    end
    exp_q.push_back(500); chk("single_trig_sample", 32'(trig_k));
    exp_q.push_back(502); chk("single_fv_after_last", 32'(fv_k));
    rd(10'd0, d); exp_q.push_back(32'(rampw(498))); chk("single_rd0", 32'(d));
    rd_done = 1'b1;
    step(1'b1, 24'd0);
    rd_done = 1'b0;
    exp_q.push_back(0); chk("single_rel_idle", 32'(state));
    n_bad = 0; n_trig = 0;
    for (int k = 0; k < 600; k++) begin
      step(1'b1, rampw(k));
      if (state != 3'd0) n_bad++;
      if (triggered) n_trig++;
    end
    exp_q.push_back(0); chk("single_no_recap_state", 32'(n_bad));
    exp_q.push_back(0); chk("single_no_recap_trig", 32'(n_trig));

    // ---- wrap-around: trigger at address 1020 with 1000 pre samples ----
    smp_valid = 1'b0;
    #2 RSTB = 1'b0;
    trig_mode = 2'b01; trig_level = 12'd1020; pre_cnt = 10'd1000; post_cnt = 10'd23;
    @(negedge CLK) RSTB = 1'b1;
    @(posedge CLK); #1;
    trig_k = -1; fv_k = -1;
    for (int k = 0; k < 2000; k++) begin
      step(1'b1, rampw(k));
      if (triggered && trig_k < 0) trig_k = k;
      if (frame_valid) begin fv_k = k; break; end
    end
    exp_q.push_back(1020); chk("wrap_trig_sample", 32'(trig_k));
    exp_q.push_back(1043); chk("wrap_fv_after_last", 32'(fv_k));
    rd(10'd0, d);    exp_q.push_back(32'(rampw(20)));   chk("wrap_rd0", 32'(d));
    rd(10'd1000, d); exp_q.push_back(32'(rampw(1020))); chk("wrap_rd1000", 32'(d));
    rd(10'd1023, d); exp_q.push_back(32'(rampw(1043))); chk("wrap_rd1023", 32'(d));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_scope_capture
